pingpong_transposer: RTL and testbench

- Parametrised, double-buffered successor to the always-out transposer used in the Gemmini datapath.
- Accepts a DIM x DIM matrix of WIDTH-bit elements, one row per beat, over a valid/ready interface.
- Emits the matrix column-wise (transpose mode) or row-wise (passthrough mode), also over valid/ready.
- Two banks alternate between fill and drain, so throughput is sustained at one row in and one column out per cycle.

---
 rtl/pingpong_transposer_pkg.sv | 19 +
 rtl/pingpong_transposer_if.sv | 35 +++
 rtl/pingpong_transposer_bank.sv | 37 +++
 rtl/pingpong_transposer.sv | 112 +++++++++++
 tb/tb_pingpong_transposer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pingpong_transposer_pkg.sv
// rtl/pingpong_transposer_pkg.sv - shared types, defaults and lane helper for the ping-pong transposer
package pingpong_transposer_pkg;

  localparam int DIM_DEFAULT   = 16;
  localparam int WIDTH_DEFAULT = 8;
  localparam int CNT_W         = $clog2(DIM_DEFAULT);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  // Bit offset of lane 'lane' inside a packed row of 'width'-bit elements.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pingpong_transposer_if.sv
// rtl/pingpong_transposer_if.sv - row-in / beat-out valid/ready bundle of the ping-pong transposer
interface pingpong_transposer_if #(
  parameter int DIM   = pingpong_transposer_pkg::DIM_DEFAULT,
  parameter int WIDTH = pingpong_transposer_pkg::WIDTH_DEFAULT
);

  logic                   in_input_0_payload_discriminant;
  logic [DIM*WIDTH-1:0]   in_input_0_payload_Some_0;
  logic                   in_input_0_mode;
  logic                   in_input_0_resolver_ready;
  logic                   out_output_payload_discriminant;
  logic [DIM*WIDTH-1:0]   out_output_payload_Some_0;
  logic                   out_output_resolver_ready;

  modport slave (
    input  in_input_0_payload_discriminant,
    input  in_input_0_payload_Some_0,
    input  in_input_0_mode,
    output in_input_0_resolver_ready,
    output out_output_payload_discriminant,
    output out_output_payload_Some_0,
    input  out_output_resolver_ready
  );

  modport master (
    output in_input_0_payload_discriminant,
    output in_input_0_payload_Some_0,
    output in_input_0_mode,
    input  in_input_0_resolver_ready,
    input  out_output_payload_discriminant,
    input  out_output_payload_Some_0,
    output out_output_resolver_ready
  );

endinterface

// File: rtl/pingpong_transposer_bank.sv
// rtl/pingpong_transposer_bank.sv - one DIM x DIM element array, row write, row-or-column read
module pingpong_transposer_bank
  import pingpong_transposer_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DIM)-1:0]   wr_row,
  input  logic [DIM*WIDTH-1:0]     wr_data,
  input  logic                     transpose,
  input  logic [$clog2(DIM)-1:0]   rd_idx,
  output logic [DIM*WIDTH-1:0]     rd_data
);

  logic [DIM*WIDTH-1:0] mem [DIM];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DIM; i++) begin
      if (transpose) begin
        rd_data[lane_lsb(i, WIDTH) +: WIDTH] = mem[i][lane_lsb(int'(rd_idx), WIDTH) +: WIDTH];
      end else begin
        rd_data[lane_lsb(i, WIDTH) +: WIDTH] = mem[rd_idx][lane_lsb(i, WIDTH) +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/pingpong_transposer.sv
// rtl/pingpong_transposer.sv - double-buffered matrix transposer: two banks alternate fill and drain
module pingpong_transposer
  import pingpong_transposer_pkg::*;
#(
  parameter int DIM   = DIM_DEFAULT,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  pingpong_transposer_if.slave bus
);

  localparam int               CW    = $clog2(DIM);
  localparam int               ROW_W = DIM * WIDTH;
  localparam logic [CW-1:0]    LAST  = CW'(DIM - 1);

  bank_state_t   st_q   [2];
  bank_state_t   st_d   [2];
  logic          mode_q [2];
  logic          mode_d [2];
  logic          fill_sel_q, fill_sel_d;
  logic          drain_sel_q, drain_sel_d;
  logic [CW-1:0] fill_row_q, fill_row_d;
  logic [CW-1:0] drain_idx_q, drain_idx_d;
  logic [ROW_W-1:0] rd_data [2];

  logic in_ready, out_valid, in_fire, out_fire;

  // Ready and valid come from registered bank state only, so nothing is combinational in->out.
  assign in_ready  = (st_q[fill_sel_q] != FULL);
  assign out_valid = (st_q[drain_sel_q] == FULL);
  assign in_fire   = bus.in_input_0_payload_discriminant && in_ready;
  assign out_fire  = out_valid && bus.out_output_resolver_ready;

  assign bus.in_input_0_resolver_ready       = in_ready;
  assign bus.out_output_payload_discriminant = out_valid;
  assign bus.out_output_payload_Some_0       = out_valid ? rd_data[drain_sel_q] : '0;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_transposer_bank #(
      .DIM   (DIM),
      .WIDTH (WIDTH)
    ) u_bank (
      .clk       (clk),
      .wr_en     (in_fire && (fill_sel_q == 1'(b))),
      .wr_row    (fill_row_q),
      .wr_data   (bus.in_input_0_payload_Some_0),
      .transpose (mode_q[b]),
      .rd_idx    (drain_idx_q),
      .rd_data   (rd_data[b])
    );
  end

  always_comb begin
    st_d[0]     = st_q[0];
    st_d[1]     = st_q[1];
    mode_d[0]   = mode_q[0];
    mode_d[1]   = mode_q[1];
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    fill_row_d  = fill_row_q;
    drain_idx_d = drain_idx_q;

    // Fill and drain always target different banks when both fire, so the updates never collide.
    if (in_fire) begin
      if (fill_row_q == '0) begin
        mode_d[fill_sel_q] = bus.in_input_0_mode;
        st_d[fill_sel_q]   = FILLING;
      end
      if (fill_row_q == LAST) begin
        st_d[fill_sel_q] = FULL;
        fill_row_d       = '0;
        fill_sel_d       = ~fill_sel_q;
      end else begin
        fill_row_d = fill_row_q + 1'b1;
      end
    end

    if (out_fire) begin
      if (drain_idx_q == LAST) begin
        st_d[drain_sel_q] = EMPTY;
        drain_idx_d       = '0;
        drain_sel_d       = ~drain_sel_q;
      end else begin
        drain_idx_d = drain_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q[0]     <= EMPTY;
      st_q[1]     <= EMPTY;
      mode_q[0]   <= 1'b0;
      mode_q[1]   <= 1'b0;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      fill_row_q  <= '0;
      drain_idx_q <= '0;
    end else begin
      st_q[0]     <= st_d[0];
      st_q[1]     <= st_d[1];
      mode_q[0]   <= mode_d[0];
      mode_q[1]   <= mode_d[1];
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      fill_row_q  <= fill_row_d;
      drain_idx_q <= drain_idx_d;
    end
  end

endmodule

// File: tb/tb_pingpong_transposer.sv
// tb/tb_pingpong_transposer.sv - scoreboard bench for the ping-pong transposer
module tb_pingpong_transposer;

  localparam int DIM   = 16;
  localparam int WIDTH = 8;
  localparam int ROW_W = DIM * WIDTH;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   n_beats;

  logic [ROW_W-1:0] exp_q    [$];
  logic [ROW_W-1:0] beat_log [$];
  int               beat_cyc [$];

  pingpong_transposer_if #(.DIM(DIM), .WIDTH(WIDTH)) bus ();

  pingpong_transposer #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] elem(input int seed, input int r, input int c);
    return WIDTH'((seed + r * 16 + c) & 255);
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input int seed, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int c = 0; c < DIM; c++) v[c*WIDTH +: WIDTH] = elem(seed, r, c);
    return v;
  endfunction

  function automatic logic [ROW_W-1:0] exp_beat(input int seed, input logic mode, input int j);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int i = 0; i < DIM; i++) v[i*WIDTH +: WIDTH] = mode ? elem(seed, i, j) : elem(seed, j, i);
    return v;
  endfunction

  function automatic int lane_at(input int beat, input int lane);
    logic [ROW_W-1:0] v;
    v = (beat_log.size() > beat) ? beat_log[beat] : '0;
    return int'(v[lane*WIDTH +: WIDTH]);
  endfunction

  function automatic int cyc_at(input int beat);
    return (beat_cyc.size() > beat) ? beat_cyc[beat] : -1;
  endfunction

  // Scoreboard monitor: every accepted output beat is popped against the expected queue.
  always @(negedge clk) begin
    if (bus.out_output_payload_discriminant && bus.out_output_resolver_ready) begin
      n_beats++;
      beat_log.push_back(bus.out_output_payload_Some_0);
      beat_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected no beat", bus.out_output_payload_Some_0);
      end else begin
        check("beat", bus.out_output_payload_Some_0, exp_q.pop_front());
      end
    end
  end

  task automatic push_expected(input int seed, input logic mode);
    for (int j = 0; j < DIM; j++) exp_q.push_back(exp_beat(seed, mode, j));
  endtask

  // Called at posedge+1; returns at posedge+1 after the row is taken.
  task automatic send_row(input logic [ROW_W-1:0] d, input logic m, output int acc_cyc, output int waits);
    logic done;
    done    = 1'b0;
    waits   = 0;
    acc_cyc = -1;
    bus.in_input_0_payload_discriminant = 1'b1;
    bus.in_input_0_payload_Some_0       = d;
    bus.in_input_0_mode                 = m;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus.in_input_0_resolver_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_input_0_payload_discriminant = 1'b0;
    if (!done) check_int("row_accept_timeout", int'(done), 1);
  endtask

  task automatic send_rows(input int seed, input logic mode, input logic flip, input int first, input int last,
                           output int stalls, output int last_cyc);
    int acc, w;
    stalls = 0;
    last_cyc = -1;
    for (int r = first; r <= last; r++) begin
      send_row(row_of(seed, r), (flip && r != 0) ? ~mode : mode, acc, w);
      stalls += w;
      last_cyc = acc;
    end
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
    check_int("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int base, stalls, tot, last, acc, w;
    n_checks = 0;
    n_fail   = 0;
    n_beats  = 0;
    rst = 1'b0;
    bus.in_input_0_payload_discriminant = 1'b0;
    bus.in_input_0_payload_Some_0       = '0;
    bus.in_input_0_mode                 = 1'b0;
    bus.out_output_resolver_ready       = 1'b1;

    // Reset and idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_out_valid", int'(bus.out_output_payload_discriminant), 0);
    check("rst_out_payload", bus.out_output_payload_Some_0, '0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_int("post_rst_in_ready", int'(bus.in_input_0_resolver_ready), 1);
    check_int("post_rst_out_valid", int'(bus.out_output_payload_discriminant), 0);
    repeat (20) @(posedge clk);
    #1;
    check_int("idle_no_beats", n_beats, 0);

    // Single transpose matrix
    base = n_beats;
    push_expected(0, 1'b1);
    send_rows(0, 1'b1, 1'b0, 0, DIM - 1, stalls, last);
    wait_drain(200);
    check_int("t2_latency", cyc_at(base), last + 1);
    check_int("t2_beat_count", n_beats - base, 16);
    check_int("t2_b3_l5", lane_at(base + 3, 5), 8'h53);
    check_int("t2_b0_l1", lane_at(base + 0, 1), 8'h10);
    check_int("t2_b15_l15", lane_at(base + 15, 15), 8'hff);

    // Streaming four matrices
    base = n_beats;
    tot  = 0;
    for (int m = 0; m < 4; m++) begin
      push_expected(m * 17 + 1, 1'b1);
      send_rows(m * 17 + 1, 1'b1, 1'b0, 0, DIM - 1, stalls, last);
      tot += stalls;
    end
    check_int("t3_in_stalls", tot, 0);
    wait_drain(200);
    check_int("t3_beat_count", n_beats - base, 64);
    check_int("t3_contiguous", cyc_at(base + 63) - cyc_at(base), 63);

    // Backpressure
    base = n_beats;
    bus.out_output_resolver_ready = 1'b0;
    push_expected(8'h40, 1'b1);
    send_rows(8'h40, 1'b1, 1'b0, 0, DIM - 1, stalls, last);
    tot = stalls;
    push_expected(8'h50, 1'b0);
    send_rows(8'h50, 1'b0, 1'b0, 0, DIM - 1, stalls, last);
    tot += stalls;
    check_int("t4_first32_stalls", tot, 0);
    push_expected(8'h60, 1'b1);
    bus.in_input_0_payload_discriminant = 1'b1;
    bus.in_input_0_payload_Some_0       = row_of(8'h60, 0);
    bus.in_input_0_mode                 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_int("t4_in_ready_low", int'(bus.in_input_0_resolver_ready), 0);
      check_int("t4_out_valid_held", int'(bus.out_output_payload_discriminant), 1);
      check("t4_out_data_held", bus.out_output_payload_Some_0, exp_beat(8'h40, 1'b1, 0));
    end
    @(posedge clk);
    #1 bus.out_output_resolver_ready = 1'b1;
    send_row(row_of(8'h60, 0), 1'b1, acc, w);
    check_int("t4_row33_after_beat15", acc, cyc_at(base + 15) + 1);
    send_rows(8'h60, 1'b1, 1'b0, 1, DIM - 1, stalls, last);
    wait_drain(300);
    check_int("t4_beat_count", n_beats - base, 48);

    // Passthrough and mixed pair with mid-matrix mode toggling
    base = n_beats;
    push_expected(0, 1'b0);
    send_rows(0, 1'b0, 1'b0, 0, DIM - 1, stalls, last);
    wait_drain(200);
    check_int("t5_b3_l5", lane_at(base + 3, 5), 8'h35);
    check_int("t5_b15_l0", lane_at(base + 15, 0), 8'hf0);
    base = n_beats;
    push_expected(8'h70, 1'b1);
    send_rows(8'h70, 1'b1, 1'b1, 0, DIM - 1, stalls, last);
    push_expected(8'h80, 1'b0);
    send_rows(8'h80, 1'b0, 1'b1, 0, DIM - 1, stalls, last);
    wait_drain(200);
    check_int("t5_mixed_count", n_beats - base, 32);
    check_int("t5_tr_b2_l1", lane_at(base + 2, 1), 8'h82);
    check_int("t5_pt_b2_l1", lane_at(base + 16 + 2, 1), 8'ha1);

    // Reset mid-fill
    base = n_beats;
    send_rows(8'h90, 1'b1, 1'b0, 0, 6, stalls, last);
    #2 rst = 1'b0;
    @(negedge clk);
    check_int("t6_rst_out_valid", int'(bus.out_output_payload_discriminant), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_int("t6_no_beats_after_rst", n_beats - base, 0);
    push_expected(8'ha0, 1'b1);
    send_rows(8'ha0, 1'b1, 1'b0, 0, DIM - 1, stalls, last);
    wait_drain(200);
    check_int("t6_fresh_count", n_beats - base, 16);
    check_int("t6_b0_l7", lane_at(base, 7), 8'h10);
    check_int("t6_latency", cyc_at(base), last + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
